// File: rtl/pipe_pal_byte_packer.sv
// Byte-to-word packer feeding pipe_pal: little-endian lane packing with
// per-lane keep mask and last flag, followed by a small output FIFO.
module pipe_pal_byte_packer #(
   parameter int W_DATA = 32,
   parameter int DEPTH  = 2
) (
   input  logic                       i_clk,
   input  logic                       resetn,
   input  logic                       i_valid,
   output logic                       o_ready,
   input  logic [7:0]                 i_byte,
   input  logic                       i_last,
   output logic                       o_valid,
   input  logic                       i_ready,
   output logic [W_DATA-1:0]          o_data,
   output logic [W_DATA/8-1:0]        o_keep,
   output logic                       o_last,
   output logic [$clog2(DEPTH):0]     o_level
);

   localparam int N  = W_DATA / 8;
   localparam int IW = $clog2(N);
   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;

   typedef enum logic {S_EMPTY, S_PARTIAL} state_t;

   state_t            r_state, w_state_nxt;
   logic [IW-1:0]     r_idx;
   logic [W_DATA-1:0] r_pack;
   logic [N-1:0]      r_keep;

   logic [W_DATA-1:0] r_fdata [DEPTH];
   logic [N-1:0]      r_fkeep [DEPTH];
   logic              r_flast [DEPTH];
   logic [PW-1:0]     r_wptr, r_rptr;
   logic [LW-1:0]     r_level;

   logic              w_accept, w_complete, w_push, w_pop;
   logic [W_DATA-1:0] w_word;
   logic [N-1:0]      w_keep;

   // Handshake and completion decode; o_ready depends only on registered level
   always_comb begin
      o_ready    = (r_level < LW'(DEPTH));
      o_valid    = (r_level != '0);
      w_accept   = i_valid && o_ready;
      w_complete = w_accept && (i_last || (r_idx == IW'(N - 1)));
      w_push     = w_complete;
      w_pop      = o_valid && i_ready;
      w_word     = r_pack | (W_DATA'(i_byte) << (8 * r_idx));
      w_keep     = r_keep | (N'(1) << r_idx);
   end

   // Pack FSM state register
   always_ff @(posedge i_clk or negedge resetn) begin
      if (!resetn) r_state <= S_EMPTY;
      else         r_state <= w_state_nxt;
   end

   // Pack FSM next state
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_EMPTY:   if (w_accept && !w_complete) w_state_nxt = S_PARTIAL;
         S_PARTIAL: if (w_complete)              w_state_nxt = S_EMPTY;
         default:                                w_state_nxt = S_EMPTY;
      endcase
   end

   // Lane index, pack register and keep mask
   always_ff @(posedge i_clk or negedge resetn) begin
      if (!resetn) begin
         r_idx  <= '0;
         r_pack <= '0;
         r_keep <= '0;
      end else if (w_complete) begin
         r_idx  <= '0;
         r_pack <= '0;
         r_keep <= '0;
      end else if (w_accept) begin
         r_idx  <= r_idx + IW'(1);
         r_pack <= w_word;
         r_keep <= w_keep;
      end
   end

   // FIFO storage; contents are masked at the output so no reset is needed
   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_fdata[r_wptr] <= w_word;
         r_fkeep[r_wptr] <= w_keep;
         r_flast[r_wptr] <= i_last;
      end
   end

   // FIFO pointers and occupancy; simultaneous push and pop leaves level unchanged
   always_ff @(posedge i_clk or negedge resetn) begin
      if (!resetn) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + PW'(1);
         if (w_pop)  r_rptr <= r_rptr + PW'(1);
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + LW'(1);
            2'b01:   r_level <= r_level - LW'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   // Head-of-FIFO outputs, zeroed while empty
   always_comb begin
      o_data  = '0;
      o_keep  = '0;
      o_last  = 1'b0;
      o_level = r_level;
      if (o_valid) begin
         o_data = r_fdata[r_rptr];
         o_keep = r_fkeep[r_rptr];
         o_last = r_flast[r_rptr];
      end
   end

endmodule

// File: tb/tb_pipe_pal_byte_packer.sv
// Scoreboard bench for pipe_pal_byte_packer (W_DATA=32, DEPTH=2).
module tb_pipe_pal_byte_packer;

   typedef struct {
      logic [31:0] data;
      logic [3:0]  keep;
      logic        last;
   } word_t;

   logic        i_clk = 1'b0;
   logic        resetn;
   logic        i_valid;
   logic        o_ready;
   logic [7:0]  i_byte;
   logic        i_last;
   logic        o_valid;
   logic        i_ready;
   logic [31:0] o_data;
   logic [3:0]  o_keep;
   logic        o_last;
   logic [1:0]  o_level;

   word_t exp_q[$];
   int    checks = 0;
   int    errors = 0;

   pipe_pal_byte_packer #(.W_DATA(32), .DEPTH(2)) dut (
      .i_clk   (i_clk),
      .resetn  (resetn),
      .i_valid (i_valid),
      .o_ready (o_ready),
      .i_byte  (i_byte),
      .i_last  (i_last),
      .o_valid (o_valid),
      .i_ready (i_ready),
      .o_data  (o_data),
      .o_keep  (o_keep),
      .o_last  (o_last),
      .o_level (o_level)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Monitor: 2 time units after each falling edge, compare the word about to be popped
   always @(negedge i_clk) begin
      #2;
      if (resetn && o_valid && i_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: actual=%0h required=none", o_data);
         end else begin
            word_t w;
            w = exp_q.pop_front();
            chk("word_data", 64'(o_data), 64'(w.data));
            chk("word_keep", 64'(o_keep), 64'(w.keep));
            chk("word_last", 64'(o_last), 64'(w.last));
         end
      end
   end

   // Drive one byte from a falling edge, wait for acceptance, return at next falling edge
   task automatic send(input logic [7:0] b, input logic l);
      int budget;
      i_valid = 1'b1;
      i_byte  = b;
      i_last  = l;
      budget  = 0;
      while (!o_ready && budget < 50) begin
         @(negedge i_clk);
         budget++;
      end
      if (!o_ready) begin
         $display("FAIL send_timeout: actual=stalled required=accept");
         errors++;
         $display("Simulation finished: %0d checks, %0d errors", checks, errors);
         $fatal(1, "stalled");
      end
      @(posedge i_clk);
      @(negedge i_clk);
      i_valid = 1'b0;
   endtask

   task automatic expect_word(input logic [31:0] d, input logic [3:0] k, input logic l);
      word_t w;
      w.data = d;
      w.keep = k;
      w.last = l;
      exp_q.push_back(w);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || o_valid) && n < 50) begin
         @(negedge i_clk);
         n++;
      end
      chk("drain_done", 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      resetn  = 1'b0;
      i_valid = 1'b0;
      i_byte  = '0;
      i_last  = 1'b0;
      i_ready = 1'b1;
      #1;
      chk("rst_valid", 64'(o_valid), 64'd0);
      chk("rst_level", 64'(o_level), 64'd0);
      chk("rst_ready", 64'(o_ready), 64'd1);
      chk("rst_data",  64'(o_data),  64'd0);
      chk("rst_keep",  64'(o_keep),  64'd0);
      chk("rst_last",  64'(o_last),  64'd0);
      @(negedge i_clk);
      @(negedge i_clk);
      resetn = 1'b1;
      @(negedge i_clk);

      // 1: full word, latency of one cycle
      send(8'h11, 1'b0);
      send(8'h22, 1'b0);
      send(8'h33, 1'b0);
      chk("t1_not_yet_valid", 64'(o_valid), 64'd0);
      expect_word(32'h44332211, 4'b1111, 1'b0);
      send(8'h44, 1'b0);
      chk("t1_valid_after", 64'(o_valid), 64'd1);
      chk("t1_level", 64'(o_level), 64'd1);
      drain();

      // 2: short packet closed by last
      send(8'hAA, 1'b0);
      expect_word(32'h0000BBAA, 4'b0011, 1'b1);
      send(8'hBB, 1'b1);
      drain();

      // 3: backpressure fills FIFO, then drains in order
      i_ready = 1'b0;
      expect_word(32'h04030201, 4'b1111, 1'b0);
      expect_word(32'h08070605, 4'b1111, 1'b0);
      for (int i = 1; i <= 8; i++) send(8'(i), 1'b0);
      chk("t3_level_full", 64'(o_level), 64'd2);
      chk("t3_ready_low",  64'(o_ready), 64'd0);
      i_ready = 1'b1;
      @(posedge i_clk);
      #1;
      chk("t3_level_after_pop", 64'(o_level), 64'd1);
      chk("t3_ready_after_pop", 64'(o_ready), 64'd1);
      @(negedge i_clk);
      drain();

      // 4: single-byte packet at lane 0
      expect_word(32'h0000005A, 4'b0001, 1'b1);
      send(8'h5A, 1'b1);
      drain();

      // 5: reset mid-operation discards a stored word and a partial word
      i_ready = 1'b0;
      for (int i = 0; i < 4; i++) send(8'hE0 + 8'(i), 1'b0);
      send(8'hF0, 1'b0);
      send(8'hF1, 1'b0);
      resetn = 1'b0;
      #1;
      chk("t5_rst_valid", 64'(o_valid), 64'd0);
      chk("t5_rst_level", 64'(o_level), 64'd0);
      chk("t5_rst_data",  64'(o_data),  64'd0);
      chk("t5_rst_ready", 64'(o_ready), 64'd1);
      @(negedge i_clk);
      resetn  = 1'b1;
      i_ready = 1'b1;
      expect_word(32'h04030201, 4'b1111, 1'b0);
      for (int i = 1; i <= 4; i++) send(8'(i), 1'b0);
      drain();
      for (int i = 0; i < 4; i++) @(negedge i_clk);
      chk("t5_no_extra", 64'(o_valid), 64'd0);

      // 6: push and pop on the same edge at level 1
      i_ready = 1'b0;
      expect_word(32'hA3A2A1A0, 4'b1111, 1'b0);
      expect_word(32'h00C2C1C0, 4'b0111, 1'b1);
      for (int i = 0; i < 4; i++) send(8'hA0 + 8'(i), 1'b0);
      send(8'hC0, 1'b0);
      send(8'hC1, 1'b0);
      chk("t6_level_pre", 64'(o_level), 64'd1);
      i_ready = 1'b1;
      send(8'hC2, 1'b1);
      chk("t6_level_same", 64'(o_level), 64'd1);
      chk("t6_valid_new",  64'(o_valid), 64'd1);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: actual=timeout required=finish");
      errors++;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule
